// File: rtl/bmem_arbiter.sv
// Arbitrates the shared 64-bit burst memory port between the icache (read-only)
// and the dcache (read/write), splitting 256-bit lines into 4 beats and assembling them back.
module bmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int BEATS      = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] i_dfp_addr,
  input  logic                  i_dfp_read,
  output logic [255:0]          i_dfp_rdata,
  output logic                  i_dfp_resp,

  input  logic [ADDR_WIDTH-1:0] d_dfp_addr,
  input  logic                  d_dfp_read,
  input  logic                  d_dfp_write,
  input  logic [255:0]          d_dfp_wdata,
  output logic [255:0]          d_dfp_rdata,
  output logic                  d_dfp_resp,

  output logic [ADDR_WIDTH-1:0] bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [63:0]           bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [ADDR_WIDTH-1:0] bmem_raddr,
  input  logic [63:0]           bmem_rdata,
  input  logic                  bmem_rvalid
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(32'h1F);
  localparam logic [1:0]            LAST_BEAT  = 2'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_DATA,
    WR_BURST,
    RESP
  } state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } grant_t;

  state_t                  state_q, state_d;
  grant_t                  last_grant_q, last_grant_d;
  grant_t                  owner_q, owner_d;
  logic                    pend_q, pend_d;
  logic                    is_write_q, is_write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              beat_q, beat_d;
  logic [255:0]            line_q, line_d;
  logic [255:0]            i_rdata_q, i_rdata_d;
  logic [255:0]            d_rdata_q, d_rdata_d;

  logic                    d_req;
  logic                    any_req;
  logic                    beat_last;
  logic                    rd_hit;
  grant_t                  pick;
  logic [ADDR_WIDTH-1:0]   pick_addr;

  assign d_req     = d_dfp_read | d_dfp_write;
  assign any_req   = i_dfp_read | d_req;
  assign beat_last = (beat_q == LAST_BEAT);
  assign rd_hit    = bmem_rvalid && (bmem_raddr == addr_q);

  // Round-robin: on contention the requester that was not granted last time wins.
  always_comb begin
    pick = GNT_I;
    if (i_dfp_read && d_req) begin
      pick = (last_grant_q == GNT_I) ? GNT_D : GNT_I;
    end else if (d_req) begin
      pick = GNT_D;
    end
    pick_addr = (pick == GNT_D) ? d_dfp_addr : i_dfp_addr;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    pend_d       = pend_q;
    is_write_d   = is_write_q;
    addr_d       = addr_q;
    beat_d       = beat_q;
    line_d       = line_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      // The grant is registered first (pend); the command starts one cycle later.
      IDLE: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          beat_d  = 2'd0;
          state_d = is_write_q ? WR_BURST : RD_CMD;
        end else if (any_req) begin
          pend_d       = 1'b1;
          owner_d      = pick;
          last_grant_d = pick;
          is_write_d   = (pick == GNT_D) && d_dfp_write;
          addr_d       = pick_addr & ALIGN_MASK;
        end
      end

      RD_CMD: begin
        if (bmem_ready) begin
          beat_d  = 2'd0;
          state_d = RD_DATA;
        end
      end

      RD_DATA: begin
        if (rd_hit) begin
          line_d[{beat_q, 6'd0} +: 64] = bmem_rdata;
          beat_d = beat_q + 2'd1;
          if (beat_last) begin
            state_d = RESP;
            if (owner_q == GNT_I) begin
              i_rdata_d = line_d;
            end else begin
              d_rdata_d = line_d;
            end
          end
        end
      end

      WR_BURST: begin
        if (bmem_ready) begin
          beat_d = beat_q + 2'd1;
          if (beat_last) begin
            state_d = RESP;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_I;
      owner_q      <= GNT_I;
      pend_q       <= 1'b0;
      is_write_q   <= 1'b0;
      addr_q       <= '0;
      beat_q       <= 2'd0;
      line_q       <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      pend_q       <= pend_d;
      is_write_q   <= is_write_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      line_q       <= line_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    bmem_addr   = addr_q;
    bmem_read   = (state_q == RD_CMD);
    bmem_write  = (state_q == WR_BURST);
    bmem_wdata  = bmem_write ? d_dfp_wdata[{beat_q, 6'd0} +: 64] : 64'd0;
    i_dfp_resp  = (state_q == RESP) && (owner_q == GNT_I);
    d_dfp_resp  = (state_q == RESP) && (owner_q == GNT_D);
    i_dfp_rdata = i_rdata_q;
    d_dfp_rdata = d_rdata_q;
  end

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter: stimulus tasks push expectations into queues,
// a negedge monitor pops and compares whenever the DUT presents a resp, write beat or accepted command.
module tb_bmem_arbiter;

  localparam int AW = 32;

  localparam logic [255:0] LINE_T1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] WR_T2   = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
                                      64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
  localparam logic [255:0] WR_LAT  = {64'hB3B3_B3B3_0000_1111, 64'hB2B2_B2B2_0000_2222,
                                      64'hB1B1_B1B1_0000_3333, 64'hB0B0_B0B0_0000_4444};
  localparam logic [255:0] LINE_A  = {64'hC103_0000_0000_0000, 64'hC102_0000_0000_0000,
                                      64'hC101_0000_0000_0000, 64'hC100_0000_0000_0000};
  localparam logic [255:0] LINE_B  = {64'hD203_0000_0000_00FF, 64'hD202_0000_0000_00FF,
                                      64'hD201_0000_0000_00FF, 64'hD200_0000_0000_00FF};
  localparam logic [255:0] LINE_C  = {64'hE303_1234_5678_0000, 64'hE302_1234_5678_0000,
                                      64'hE301_1234_5678_0000, 64'hE300_1234_5678_0000};
  localparam logic [255:0] LINE_D  = {64'hF403_0000_FFFF_0000, 64'hF402_0000_FFFF_0000,
                                      64'hF401_0000_FFFF_0000, 64'hF400_0000_FFFF_0000};
  localparam logic [255:0] LINE_T4 = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                                      64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
  localparam logic [255:0] WR_T5   = {64'h5353_5353_5353_5353, 64'h5252_5252_5252_5252,
                                      64'h5151_5151_5151_5151, 64'h5050_5050_5050_5050};
  localparam logic [255:0] LINE_T5 = {64'h6666_0000_0000_0004, 64'h6666_0000_0000_0003,
                                      64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001};
  localparam logic [255:0] LINE_T6 = {64'h7777_7777_0000_0004, 64'h7777_7777_0000_0003,
                                      64'h7777_7777_0000_0002, 64'h7777_7777_0000_0001};

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] i_dfp_addr;
  logic          i_dfp_read;
  logic [255:0]  i_dfp_rdata;
  logic          i_dfp_resp;
  logic [AW-1:0] d_dfp_addr;
  logic          d_dfp_read;
  logic          d_dfp_write;
  logic [255:0]  d_dfp_wdata;
  logic [255:0]  d_dfp_rdata;
  logic          d_dfp_resp;
  logic [AW-1:0] bmem_addr;
  logic          bmem_read;
  logic          bmem_write;
  logic [63:0]   bmem_wdata;
  logic          bmem_ready;
  logic [AW-1:0] bmem_raddr;
  logic [63:0]   bmem_rdata;
  logic          bmem_rvalid;

  always #5 clk = ~clk;

  bmem_arbiter #(.ADDR_WIDTH(AW), .BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .i_dfp_addr(i_dfp_addr), .i_dfp_read(i_dfp_read),
    .i_dfp_rdata(i_dfp_rdata), .i_dfp_resp(i_dfp_resp),
    .d_dfp_addr(d_dfp_addr), .d_dfp_read(d_dfp_read), .d_dfp_write(d_dfp_write),
    .d_dfp_wdata(d_dfp_wdata), .d_dfp_rdata(d_dfp_rdata), .d_dfp_resp(d_dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  typedef struct {
    bit           isD;
    bit           isRead;
    logic [255:0] line;
  } resp_t;

  resp_t       expResp[$];
  logic [63:0] expWBeat[$];
  logic [31:0] expCmd[$];
  resp_t       monE;
  int          checks = 0;
  int          errors = 0;
  int          cycCount = 0;
  int          lastRespCyc = -100;
  bit          monitorOn = 1'b0;

  always @(posedge clk) cycCount <= cycCount + 1;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit iRd, input logic [31:0] iAddr, input bit dRd, input bit dWr,
                               input logic [31:0] dAddr, input logic [255:0] dWdata);
    i_dfp_read  = iRd;
    i_dfp_addr  = iAddr;
    d_dfp_read  = dRd;
    d_dfp_write = dWr;
    d_dfp_addr  = dAddr;
    d_dfp_wdata = dWdata;
  endtask

  // Monitor: every presented resp, write beat and accepted read command is matched against the queues.
  always @(negedge clk) begin
    if (monitorOn) begin
      if (i_dfp_resp || d_dfp_resp) begin
        if (expResp.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_resp: got i=%0b d=%0b expected none", i_dfp_resp, d_dfp_resp);
        end else begin
          monE = expResp.pop_front();
          checkOutput("resp_i", i_dfp_resp, !monE.isD);
          checkOutput("resp_d", d_dfp_resp, monE.isD);
          if (monE.isRead)
            checkOutput(monE.isD ? "rdata_d" : "rdata_i", monE.isD ? d_dfp_rdata : i_dfp_rdata, monE.line);
          lastRespCyc = cycCount;
        end
      end
      if (bmem_write) begin
        if (expWBeat.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_wbeat: got %0h expected none", bmem_wdata);
        end else begin
          checkOutput("wdata", bmem_wdata, expWBeat.pop_front());
        end
      end
      if (bmem_read && bmem_ready) begin
        if (expCmd.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rd_cmd: got addr %0h expected none", bmem_addr);
        end else begin
          checkOutput("rd_cmd_addr", bmem_addr, expCmd.pop_front());
        end
      end
    end
  end

  // Serves one read whose request is already raised; optionally drops it in the resp cycle.
  task automatic serviceRead(input bit isD, input logic [31:0] lineAddr, input logic [255:0] line,
                             input int stall, input bit inject, input bit dropAfter);
    resp_t r;
    int n;
    int beatCyc;
    r.isD = isD;
    r.isRead = 1'b1;
    r.line = line;
    expCmd.push_back(lineAddr);
    expResp.push_back(r);
    n = 0;
    while (!bmem_read && n < 20) begin
      tick();
      n++;
    end
    if (!bmem_read) begin
      checkOutput("rd_cmd_timeout", 1'b0, 1'b1);
      return;
    end
    bmem_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      checkOutput("rd_hold_read", bmem_read, 1'b1);
      checkOutput("rd_hold_addr", bmem_addr, lineAddr);
      tick();
    end
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    checkOutput("rd_cmd_deassert", bmem_read, 1'b0);
    beatCyc = cycCount;
    for (int b = 0; b < 4; b++) begin
      if (inject && b == 2) begin
        bmem_rvalid = 1'b1;
        bmem_raddr  = lineAddr ^ 32'h0000_0100;
        bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
      end
      bmem_rvalid = 1'b1;
      bmem_raddr  = lineAddr;
      bmem_rdata  = line[64*b +: 64];
      beatCyc     = cycCount;
      tick();
    end
    bmem_rvalid = 1'b0;
    bmem_rdata  = 64'd0;
    if (dropAfter) begin
      if (isD) d_dfp_read = 1'b0;
      else     i_dfp_read = 1'b0;
    end
    tick();
    checkOutput("rd_resp_seen", expResp.size(), 0);
    checkOutput("rd_resp_latency", lastRespCyc, beatCyc + 1);
  endtask

  // Serves a dcache write already raised at cycle startCyc; abortBeat>=0 pulls reset in that beat.
  task automatic serviceWrite(input logic [31:0] lineAddr, input logic [255:0] wdata, input int stallBeat,
                              input int stallLen, input int abortBeat, input int startCyc);
    resp_t r;
    int n;
    int lastBeatCyc;
    for (int b = 0; b < 4; b++) begin
      if (abortBeat >= 0 && b > abortBeat) break;
      if (b == stallBeat)
        for (int s = 0; s < stallLen; s++) expWBeat.push_back(wdata[64*b +: 64]);
      expWBeat.push_back(wdata[64*b +: 64]);
    end
    if (abortBeat < 0) begin
      r.isD = 1'b1;
      r.isRead = 1'b0;
      r.line = '0;
      expResp.push_back(r);
    end
    n = 0;
    while (!bmem_write && n < 20) begin
      tick();
      n++;
    end
    if (!bmem_write) begin
      checkOutput("wr_burst_timeout", 1'b0, 1'b1);
      return;
    end
    checkOutput("wr_addr", bmem_addr, lineAddr);
    lastBeatCyc = cycCount;
    for (int b = 0; b < 4; b++) begin
      if (b == abortBeat) begin
        bmem_ready = 1'b1;
        rst = 1'b0;
        tick();
        return;
      end
      if (b == stallBeat) begin
        bmem_ready = 1'b0;
        repeat (stallLen) tick();
      end
      bmem_ready  = 1'b1;
      lastBeatCyc = cycCount;
      tick();
    end
    bmem_ready  = 1'b0;
    d_dfp_write = 1'b0;
    tick();
    checkOutput("wr_resp_seen", expResp.size(), 0);
    checkOutput("wr_resp_after_last", lastRespCyc, lastBeatCyc + 1);
    if (startCyc >= 0) checkOutput("wr_latency", lastRespCyc - startCyc, 6);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_bmem_read"}, bmem_read, 1'b0);
    checkOutput({tag, "_bmem_write"}, bmem_write, 1'b0);
    checkOutput({tag, "_bmem_addr"}, bmem_addr, 32'd0);
    checkOutput({tag, "_bmem_wdata"}, bmem_wdata, 64'd0);
    checkOutput({tag, "_i_resp"}, i_dfp_resp, 1'b0);
    checkOutput({tag, "_d_resp"}, d_dfp_resp, 1'b0);
    checkOutput({tag, "_i_rdata"}, i_dfp_rdata, 256'd0);
    checkOutput({tag, "_d_rdata"}, d_dfp_rdata, 256'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int startCyc;
    rst = 1'b0;
    bmem_ready = 1'b0;
    bmem_raddr = '0;
    bmem_rdata = '0;
    bmem_rvalid = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0);
    tick();
    tick();
    checkAllZero("reset");
    rst = 1'b1;
    monitorOn = 1'b1;
    tick();

    $display("[TB] icache read 0x1234");
    applyStimulus(1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'd0, 256'd0);
    serviceRead(1'b0, 32'h0000_1220, LINE_T1, 0, 1'b0, 1'b1);

    $display("[TB] dcache write 0x80 with stall on beat 1");
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0080, WR_T2);
    serviceWrite(32'h0000_0080, WR_T2, 1, 2, -1, -1);

    $display("[TB] dcache write 0xC4 latency");
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_00C4, WR_LAT);
    startCyc = cycCount;
    serviceWrite(32'h0000_00C0, WR_LAT, -1, 0, -1, startCyc);

    $display("[TB] contested requests, round robin");
    applyStimulus(1'b1, 32'h0000_2000, 1'b1, 1'b0, 32'h0000_3000, 256'd0);
    serviceRead(1'b0, 32'h0000_2000, LINE_A, 0, 1'b0, 1'b0);
    serviceRead(1'b1, 32'h0000_3000, LINE_B, 0, 1'b0, 1'b0);
    serviceRead(1'b0, 32'h0000_2000, LINE_C, 0, 1'b0, 1'b1);
    serviceRead(1'b1, 32'h0000_3000, LINE_D, 0, 1'b0, 1'b1);

    $display("[TB] dcache read with mismatched raddr beat");
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_4010, 256'd0);
    serviceRead(1'b1, 32'h0000_4000, LINE_T4, 0, 1'b1, 1'b1);
    checkOutput("i_rdata_hold", i_dfp_rdata, LINE_C);

    $display("[TB] reset during write beat 2");
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0500, WR_T5);
    serviceWrite(32'h0000_0500, WR_T5, -1, 0, 2, -1);
    checkAllZero("abort");
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0);
    bmem_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    checkOutput("abort_no_write", bmem_write, 1'b0);
    applyStimulus(1'b1, 32'h0000_0600, 1'b0, 1'b0, 32'd0, 256'd0);
    serviceRead(1'b0, 32'h0000_0600, LINE_T5, 0, 1'b0, 1'b1);

    $display("[TB] icache read with 5-cycle command stall");
    applyStimulus(1'b1, 32'h0000_7008, 1'b0, 1'b0, 32'd0, 256'd0);
    serviceRead(1'b0, 32'h0000_7000, LINE_T6, 5, 1'b0, 1'b1);

    tick();
    tick();
    checkOutput("resp_queue_empty", expResp.size(), 0);
    checkOutput("wbeat_queue_empty", expWBeat.size(), 0);
    checkOutput("cmd_queue_empty", expCmd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bmem_arbiter.md
Name: bmem_arbiter

Overview:
- Shares the single 64-bit burst memory port (bmem) between the instruction cache (read-only) and the data cache (read/write).
- Each cache presents a 256-bit line request.
- The arbiter grants one requester, issues the bmem command, and serializes write lines into 4 beats.
- It collects 4 read beats into a line and returns a one-cycle response to the granted cache only.
- Sits between the cache dfp ports and the top-level bmem interface.

Parameters:
- ADDR_WIDTH, 32, byte address width of cache and bmem addresses.
- BEATS, 4, beats per 256-bit line; fixed at 4 for a 64-bit bus; other values are unsupported.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets)
- i_dfp_addr  in  ADDR_WIDTH  icache line address
- i_dfp_read  in  1  icache read request, held until i_dfp_resp
- i_dfp_rdata  out  256  icache returned line
- i_dfp_resp  out  1  icache one-cycle completion pulse
- d_dfp_addr  in  ADDR_WIDTH  dcache line address
- d_dfp_read  in  1  dcache read request, held until d_dfp_resp
- d_dfp_write  in  1  dcache write request, held until d_dfp_resp; never asserted together with d_dfp_read
- d_dfp_wdata  in  256  dcache write line, stable while d_dfp_write
- d_dfp_rdata  out  256  dcache returned line
- d_dfp_resp  out  1  dcache one-cycle completion pulse
- bmem_addr  out  ADDR_WIDTH  line-aligned command address
- bmem_read  out  1  read command
- bmem_write  out  1  write beat valid
- bmem_wdata  out  64  write beat data
- bmem_ready  in  1  memory accepts the command/beat this cycle
- bmem_raddr  in  ADDR_WIDTH  address tag of the returning read data
- bmem_rdata  in  64  read beat data
- bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset (rst==0): state IDLE, last_grant=I, beat counter 0, line buffer 0. All outputs 0: bmem_read, bmem_write, bmem_addr, bmem_wdata, both resp, both rdata.
- bmem_addr = granted address with bits [4:0] forced to 0. It is held constant from grant until return to IDLE.
- States: IDLE, RD_CMD, RD_DATA, WR_BURST, RESP.
- IDLE:
  - If only one cache requests, grant it.
  - If both request, grant the one not equal to last_grant (round-robin).
  - Update last_grant on grant.
  - Go to RD_CMD for a read, WR_BURST for a write.
  - The grant takes 1 cycle; the bmem command starts in the next cycle.
- RD_CMD:
  - Assert bmem_read.
  - On bmem_ready, deassert next cycle and go to RD_DATA with beat=0.
  - If not ready, hold the command.
- RD_DATA:
  - Each cycle with bmem_rvalid and bmem_raddr equal to the latched line address, store bmem_rdata into buffer bits [64*beat+63 : 64*beat] and increment beat.
  - rvalid with a mismatched raddr is ignored.
  - After beat 3 is stored, go to RESP.
- WR_BURST:
  - Assert bmem_write; bmem_wdata = d_dfp_wdata[64*beat+63 : 64*beat].
  - Beat advances only on cycles with bmem_ready.
  - After beat 3 is accepted, go to RESP.
  - Stalls (ready low) hold the beat and data.
- RESP:
  - Exactly one cycle: assert the granted cache's resp.
  - For a read, drive the assembled line on that cache's rdata; rdata holds its value until the next read completes for that cache.
  - Go to IDLE.
- Latency, read with ready high and beats back-to-back from cycle N: resp in cycle N+1 after the last beat. Write with ready always high: request seen in IDLE at T, resp at T+6.
- A new grant is never issued in the RESP cycle. A requester whose request is still high in IDLE after its resp is treated as a new request.
- Requests arriving while busy wait; a request dropped before grant is not served.
- A reset mid-burst aborts immediately to IDLE; partial line data is discarded and no resp is issued.
- The non-granted cache's resp is never asserted.

Test Plan:
- Icache read of 0x0000_1234: bmem_addr=0x0000_1220, bmem_read for 1 cycle. Beats 0x11..,0x22..,0x33..,0x44.. → i_dfp_rdata={0x44..,0x33..,0x22..,0x11..}, i_dfp_resp for 1 cycle, d_dfp_resp stays 0.
- Dcache write to 0x80 with wdata words W0..W3, bmem_ready low on the 2nd beat for 2 cycles → bmem_wdata sequence W0,W1,W1,W1,W2,W3; d_dfp_resp 1 cycle after W3 is accepted.
- Both caches request in the same cycle, repeated 3 times → grants alternate I,D,I. Each resp goes only to its owner with the correct line.
- Read in flight, with an rvalid beat carrying a mismatched raddr injected mid-burst → that beat is ignored; the assembled line contains only the 4 matching beats.
- rst driven low during beat 2 of a write → all outputs 0 the next cycle, no resp. A subsequent icache read completes normally.
- bmem_ready held low for 5 cycles on a read command → bmem_read and bmem_addr are held stable throughout; the command is issued once.
